// File: rtl/pc_gen_pkg.sv
// Shared types for the program-counter generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } state_t;

endpackage

// File: rtl/pc_fetch_counter.sv
// Free-running wrap-around event counter with enable and async active-low reset.
module pc_fetch_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: fetch handshake, redirects with epoch tagging, fetch counter.
// Build option PC_MISALIGN_TRAP_EN rejects misaligned redirects and reports them.
//
//   state | meaning
//   BOOT  | first cycle after reset release, no fetch
//   RUN   | sequential fetch, request valid unless stalled
//   REDIR | one-cycle bubble after an accepted redirect
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              INC       = 4,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_target_i,
    output logic             fetch_valid_o,
    input  logic             fetch_ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus_o,
    output logic             fetch_epoch_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic             misalign_o,
    output logic [XLEN-1:0]  misalign_addr_o
);

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_epoch;
    logic            w_fetch_valid;
    logic            w_fire;
    logic            w_redir;
    logic [XLEN-1:0] w_target;

    assign w_fetch_valid = (r_state == RUN) && !stall_i;
    assign w_fire        = w_fetch_valid && fetch_ready_i;

`ifdef PC_MISALIGN_TRAP_EN
    logic            w_misalign;
    logic            r_misalign;
    logic [XLEN-1:0] r_misalign_addr;

    assign w_misalign = redirect_valid_i && (redirect_target_i[1:0] != 2'b00);
    assign w_redir    = redirect_valid_i && !w_misalign;
    assign w_target   = redirect_target_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign <= w_misalign;
            if (w_misalign) begin
                r_misalign_addr <= redirect_target_i;
            end
        end
    end

    assign misalign_o      = r_misalign;
    assign misalign_addr_o = r_misalign_addr;
`else
    // Misaligned targets are silently aligned down to a word boundary.
    assign w_redir         = redirect_valid_i;
    assign w_target        = redirect_target_i & {{(XLEN-2){1'b1}}, 2'b00};
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_VEC;
            r_epoch <= 1'b0;
        end else if (w_redir) begin
            r_state <= REDIR;
            r_pc    <= w_target;
            r_epoch <= ~r_epoch;
        end else begin
            r_state <= RUN;
            if (w_fire) begin
                r_pc <= r_pc + XLEN'(INC);
            end
        end
    end

    pc_fetch_counter #(
        .CNT_W (CNT_W)
    ) u_fetch_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_fire),
        .o_cnt (fetch_cnt_o)
    );

    assign fetch_valid_o = w_fetch_valid;
    assign pc_o          = r_pc;
    assign pc_plus_o     = r_pc + XLEN'(INC);
    assign fetch_epoch_o = r_epoch;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver updates a cycle-level reference model and
// queues expectations; a monitor pops and compares each cycle and on each fetch handshake.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_target_i = '0;
    logic        fetch_ready_i = 1'b0;
    logic        fetch_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_o;
    logic        fetch_epoch_o;
    logic [15:0] fetch_cnt_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (RV),
        .INC       (4),
        .CNT_W     (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .fetch_valid_o     (fetch_valid_o),
        .fetch_ready_i     (fetch_ready_i),
        .pc_o              (pc_o),
        .pc_plus_o         (pc_plus_o),
        .fetch_epoch_o     (fetch_epoch_o),
        .fetch_cnt_o       (fetch_cnt_o),
        .misalign_o        (misalign_o),
        .misalign_addr_o   (misalign_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ep;
        logic [15:0] cnt;
        logic        mis;
        logic [31:0] maddr;
    } exp_t;

    exp_t        q_cyc[$];
    logic [32:0] q_fire[$];

    int n_tot  = 0;
    int n_pass = 0;

    // Reference model: bubble counts cycles until a request may be presented.
    logic [31:0] m_pc    = RV;
    logic        m_epoch = 1'b0;
    logic [15:0] m_cnt   = '0;
    int          m_bubble = 1;
    logic        m_mis   = 1'b0;
    logic [31:0] m_maddr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic step(input logic rst, input logic st, input logic rdy,
                        input logic rv, input logic [31:0] tgt);
        exp_t e;
        logic fire;
        logic acc;
        logic mis;
        @(negedge clk);
        rst_n             = rst;
        stall_i           = st;
        fetch_ready_i     = rdy;
        redirect_valid_i  = rv;
        redirect_target_i = tgt;
        if (!rst) begin
            m_pc = RV; m_epoch = 1'b0; m_cnt = '0; m_bubble = 1;
            m_mis = 1'b0; m_maddr = '0;
            e.v = 1'b0;
        end else begin
            e.v = (m_bubble == 0) && !st;
        end
        e.pc = m_pc; e.ep = m_epoch; e.cnt = m_cnt; e.mis = m_mis; e.maddr = m_maddr;
        if (rst) begin
            fire = e.v && rdy;
            if (fire) begin
                q_fire.push_back({m_epoch, m_pc});
                m_cnt = m_cnt + 16'd1;
            end
            acc = rv;
            mis = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            if (rv && tgt[1:0] != 2'b00) begin
                acc = 1'b0;
                mis = 1'b1;
            end
`endif
            if (acc) begin
                m_pc = {tgt[31:2], 2'b00};
                m_epoch = ~m_epoch;
                m_bubble = 1;
            end else begin
                if (fire) m_pc = m_pc + 32'd4;
                if (m_bubble > 0) m_bubble = m_bubble - 1;
            end
            m_mis = mis;
            if (mis) m_maddr = tgt;
        end
        q_cyc.push_back(e);
    endtask

    // Monitor: samples 3 time units after the driver, well before the rising edge.
    always @(negedge clk) begin
        exp_t e;
        logic [32:0] f;
        #3;
        if (q_cyc.size() > 0) begin
            e = q_cyc.pop_front();
            chk("fetch_valid", {31'd0, fetch_valid_o}, {31'd0, e.v});
            chk("pc", pc_o, e.pc);
            chk("pc_plus", pc_plus_o, e.pc + 32'd4);
            chk("epoch", {31'd0, fetch_epoch_o}, {31'd0, e.ep});
            chk("fetch_cnt", {16'd0, fetch_cnt_o}, {16'd0, e.cnt});
            chk("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
            chk("misalign_addr", misalign_addr_o, e.maddr);
            if (fetch_valid_o && fetch_ready_i) begin
                if (q_fire.size() == 0) begin
                    chk("unexpected_fire", 32'd1, 32'd0);
                end else begin
                    f = q_fire.pop_front();
                    chk("fire_pc", pc_o, f[31:0]);
                    chk("fire_epoch", {31'd0, fetch_epoch_o}, {31'd0, f[32]});
                end
            end
        end
    end

    initial begin
        logic [31:0] t;
        // reset, boot, sequential fetch
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        // back-pressure at 0x104
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        // redirect while pending at 0x108
        step(1, 0, 0, 1, 32'h2000);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        // back-to-back redirects
        step(1, 0, 1, 1, 32'h3000);
        step(1, 0, 1, 1, 32'h4000);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        // wrap at top of address space
        step(1, 0, 1, 1, 32'hFFFF_FFFC);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        // stall in RUN, redirect during stall
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 32'h5000);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        // misaligned redirect
        step(1, 0, 1, 1, 32'h2002);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        // reset asserted mid-handshake
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            t = $urandom();
            if ($urandom_range(0, 2) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 t);
        end
        @(negedge clk);
        #6;
        chk("cycle_queue_drained", q_cyc.size(), 32'd0);
        chk("fire_queue_drained", q_fire.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
